data_mem_responder: RTL and testbench

Data-memory responder on the MEM side of the pipelined ARM-style CPU. It is the far end of the load/store interface that the EXE/MEM register drives: address, store data, data size and load/store flag. It accepts one request at a time, models a fixed multi-cycle access latency, and performs byte, halfword or word reads and writes on a big-endian byte array. While an access is pending it raises a stall so the pipeline holds.

---
 rtl/data_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, models a fixed
// access latency and performs big-endian byte/halfword/word accesses.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Illegal size, misalignment, or access running past the end of memory.
    function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size);
        logic [2:0]  nbytes;
        logic        bad;
        logic [32:0] end_addr;
        case (size)
            2'b00:   begin nbytes = 3'd1; bad = 1'b0;                end
            2'b01:   begin nbytes = 3'd2; bad = addr[0];             end
            2'b10:   begin nbytes = 3'd4; bad = (addr[1:0] != 2'b00); end
            default: begin nbytes = 3'd1; bad = 1'b1;                end
        endcase
        end_addr = {1'b0, addr} + {30'd0, nbytes};
        return bad | (end_addr > 33'(DEPTH));
    endfunction

    // Big-endian assembly of the addressed bytes plus sign/zero extension.
    function automatic logic [31:0] load_extend(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3,
                                                input logic [1:0] size, input logic sgn);
        logic [31:0] value;
        case (size)
            2'b00:   value = {{24{sgn & b0[7]}}, b0};
            2'b01:   value = {{16{sgn & b0[7]}}, b0, b1};
            2'b10:   value = {b0, b1, b2, b3};
            default: value = 32'd0;
        endcase
        return value;
    endfunction

    logic [7:0]    mem_r [DEPTH];
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [1:0]    size_r;
    logic          write_r;
    logic          signed_r;

    logic          accept_s;
    logic          req_err_s;
    logic          do_access_s;
    logic          err_s;
    logic [AW-1:0] acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [1:0]    acc_size_s;
    logic          acc_write_s;
    logic          acc_signed_s;
    logic [7:0]    byte0_s, byte1_s, byte2_s, byte3_s;
    logic [31:0]   load_s;

    assign accept_s  = req_valid && (state_r != WAIT);
    assign req_err_s = access_error(req_addr, req_size);
    assign stall     = (state_r == WAIT) ? 1'b1 : req_valid;

    // Access operands: latched request while waiting, live request for a single-cycle access.
    always_comb begin
        acc_addr_s   = req_addr[AW-1:0];
        acc_wdata_s  = req_wdata;
        acc_size_s   = req_size;
        acc_write_s  = req_write;
        acc_signed_s = req_signed;
        if (state_r == WAIT) begin
            acc_addr_s   = addr_r;
            acc_wdata_s  = wdata_r;
            acc_size_s   = size_r;
            acc_write_s  = write_r;
            acc_signed_s = signed_r;
        end else begin
            acc_addr_s   = req_addr[AW-1:0];
            acc_wdata_s  = req_wdata;
            acc_size_s   = req_size;
            acc_write_s  = req_write;
            acc_signed_s = req_signed;
        end
    end

    // Next-state logic: acceptance, latency countdown and access trigger.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        do_access_s = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (req_valid) begin
                    if (req_err_s) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else if (SINGLE_CYCLE) begin
                        state_s     = DONE;
                        do_access_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s     = DONE;
                    do_access_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Read the addressed bytes (wrapping indices only matter for narrower accesses).
    always_comb begin
        byte0_s = mem_r[acc_addr_s];
        byte1_s = mem_r[acc_addr_s + AW'(1)];
        byte2_s = mem_r[acc_addr_s + AW'(2)];
        byte3_s = mem_r[acc_addr_s + AW'(3)];
        load_s  = load_extend(byte0_s, byte1_s, byte2_s, byte3_s, acc_size_s, acc_signed_s);
    end

    // Storage array; contents survive reset, writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (do_access_s && acc_write_s && !reset) begin
            case (acc_size_s)
                2'b00: begin
                    mem_r[acc_addr_s] <= acc_wdata_s[7:0];
                end
                2'b01: begin
                    mem_r[acc_addr_s]          <= acc_wdata_s[15:8];
                    mem_r[acc_addr_s + AW'(1)] <= acc_wdata_s[7:0];
                end
                2'b10: begin
                    mem_r[acc_addr_s]          <= acc_wdata_s[31:24];
                    mem_r[acc_addr_s + AW'(1)] <= acc_wdata_s[23:16];
                    mem_r[acc_addr_s + AW'(2)] <= acc_wdata_s[15:8];
                    mem_r[acc_addr_s + AW'(3)] <= acc_wdata_s[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    // State, countdown and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= CW'(0);
            addr_r   <= AW'(0);
            wdata_r  <= 32'd0;
            size_r   <= 2'b00;
            write_r  <= 1'b0;
            signed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r   <= req_addr[AW-1:0];
                wdata_r  <= req_wdata;
                size_r   <= req_size;
                write_r  <= req_write;
                signed_r <= req_signed;
            end
        end
    end

    // Registered response, asserted only for the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= (state_s == DONE);
            resp_err   <= err_s;
            resp_rdata <= (do_access_s && !acc_write_s) ? load_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=1 responder against a byte-array model.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        v2, v1;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        s2, rv2, e2, s1, rv1, e1;
    logic [31:0] rd2, rd1;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [2][256];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .stall(s2), .resp_valid(rv2),
        .resp_rdata(rd2), .resp_err(e2));

    data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .stall(s1), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(e1));

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        return (longint'(a) + longint'(nbytes(sz))) > 64'd256;
    endfunction

    function automatic logic [31:0] m_load(input int s, input logic [31:0] a,
                                          input logic [1:0] sz, input bit sg);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, ref_mem[s][int'(a[7:0]) + i]};
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic m_store(input int s, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
        int n;
        logic [31:0] t;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            t = wd >> (8 * (n - 1 - i));
            ref_mem[s][int'(a[7:0]) + i] = t[7:0];
        end
    endtask

    // Drives one request to instance sel (1 = LATENCY 1) and reports what it saw.
    task automatic xact(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit sg,
                        output logic [31:0] rd, output logic e, output int lat, output bit st_ok);
        req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
        if (sel) v1 = 1'b1; else v2 = 1'b1;
        st_ok = 1'b1; lat = 0; rd = 32'd0; e = 1'b0;
        #1;
        if ((sel ? s1 : s2) !== 1'b1) st_ok = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            #1;
            lat++;
            if ((sel ? rv1 : rv2) === 1'b1) begin
                rd = sel ? rd1 : rd2;
                e  = sel ? e1 : e2;
                break;
            end
            if ((sel ? s1 : s2) !== 1'b1) st_ok = 1'b0;
            @(posedge clk);
        end
        v1 = 1'b0; v2 = 1'b0;
        #1;
        if ((sel ? s1 : s2) !== 1'b0) st_ok = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transaction plus full comparison against the model.
    task automatic run_checked(input string name, input bit sel, input bit w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [1:0] sz, input bit sg);
        logic [31:0] rd, exp_rd;
        logic e;
        int lat, exp_lat;
        bit st_ok, exp_e;
        int s;
        s = sel ? 1 : 0;
        exp_e   = m_err(a, sz);
        exp_rd  = (exp_e || w) ? 32'd0 : m_load(s, a, sz, sg);
        exp_lat = exp_e ? 1 : (sel ? 1 : 2);
        xact(sel, w, a, wd, sz, sg, rd, e, lat, st_ok);
        if (!exp_e && w) m_store(s, a, sz, wd);
        checks++;
        if (rd !== exp_rd || e !== exp_e || lat != exp_lat || !st_ok) begin
            errors++;
            $display("FAIL %s: addr %h size %0d got rdata %h err %b lat %0d stall_ok %0d, expected rdata %h err %b lat %0d stall_ok 1",
                     name, a, sz, rd, e, lat, st_ok, exp_rd, exp_e, exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; v2 = 1'b0; v1 = 1'b0;
        req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'd0; req_signed = 1'b0;
        #1 reset = 1'b1;
        #11;
        checks++;
        if ({rv2, rd2, e2, s2, rv1, rd1, e1, s1} !== 68'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {rv2, rd2, e2, s2, rv1, rd1, e1, s1});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic prefill();
        logic [31:0] rd, wd;
        logic e;
        int lat;
        bit st_ok;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a += 4) begin
                wd = $urandom;
                if (wd == 32'hDEAD_BEEF) wd = wd ^ 32'd1;
                xact(s[0], 1'b1, 32'(a), wd, 2'd2, 1'b0, rd, e, lat, st_ok);
                m_store(s, 32'(a), 2'd2, wd);
            end
        end
        idle(1);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic e;
        int lat, pulses;
        bit st_ok;
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_size = 2'd2;
        v2 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({rv2, rd2, e2} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid_wait_outputs: got %h expected 0", {rv2, rd2, e2});
        end
        v2 = 1'b0;
        #1;
        checks++;
        if (s2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_stall: got %b expected 0", s2);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (rv2 === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulses);
        end
        run_checked("reset_aborted_store", 1'b0, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
        xact(1'b0, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, rd, e, lat, st_ok);
        checks++;
        if (rd === 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_store_leaked: got %h expected not deadbeef", rd);
        end
        idle(1);
    endtask

    task automatic test_word_latency();
        run_checked("word_store_20", 1'b0, 1'b1, 32'h20, 32'h1122_3344, 2'd2, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (rv2 !== 1'b0) begin
            errors++;
            $display("FAIL resp_pulse_width: got %b expected 0", rv2);
        end
        run_checked("word_load_20", 1'b0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
        idle(1);
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic e;
        int lat;
        bit st_ok;
        logic [31:0] exp_v [4];
        logic [31:0] adr [4];
        logic [1:0]  szs [4];
        bit          sgn [4];
        exp_v = '{32'h0000_0011, 32'h0000_3344, 32'hFFFF_FF80, 32'h1122_3380};
        adr   = '{32'h20, 32'h22, 32'h23, 32'h20};
        szs   = '{2'd0, 2'd1, 2'd0, 2'd2};
        sgn   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                xact(1'b0, 1'b1, 32'h23, 32'h0000_0080, 2'd0, 1'b0, rd, e, lat, st_ok);
                m_store(0, 32'h23, 2'd0, 32'h80);
            end
            xact(1'b0, 1'b0, adr[i], 32'd0, szs[i], sgn[i], rd, e, lat, st_ok);
            checks++;
            if (rd !== exp_v[i] || e !== 1'b0 || lat != 2) begin
                errors++;
                $display("FAIL subword_%0d: got %h err %b lat %0d expected %h err 0 lat 2",
                         i, rd, e, lat, exp_v[i]);
            end
        end
        idle(1);
    endtask

    task automatic test_errors();
        run_checked("err_word_misalign", 1'b0, 1'b0, 32'h21, 32'd0, 2'd2, 1'b0);
        run_checked("err_half_store_odd", 1'b0, 1'b1, 32'h01, 32'hAAAA_5555, 2'd1, 1'b0);
        run_checked("err_size_11", 1'b0, 1'b1, 32'h40, 32'h1234_5678, 2'd3, 1'b0);
        run_checked("err_word_past_end", 1'b0, 1'b0, 32'hFE, 32'd0, 2'd2, 1'b0);
        run_checked("err_lat1_oob", 1'b1, 1'b1, 32'h100, 32'h5, 2'd0, 1'b0);
        run_checked("mem_unchanged_00", 1'b0, 1'b0, 32'h00, 32'd0, 2'd2, 1'b0);
        run_checked("mem_unchanged_40", 1'b0, 1'b0, 32'h40, 32'd0, 2'd2, 1'b0);
        run_checked("edge_word_fc", 1'b0, 1'b1, 32'hFC, 32'hCAFE_F00D, 2'd2, 1'b0);
        run_checked("edge_half_fe", 1'b0, 1'b0, 32'hFE, 32'd0, 2'd1, 1'b1);
        run_checked("edge_byte_ff", 1'b0, 1'b0, 32'hFF, 32'd0, 2'd0, 1'b1);
        idle(1);
    endtask

    task automatic test_back_to_back();
        run_checked("b2b_first", 1'b0, 1'b1, 32'h60, 32'h8899_AABB, 2'd2, 1'b0);
        req_write = 1'b0; req_addr = 32'h60; req_size = 2'd1; req_signed = 1'b1; v2 = 1'b1;
        #1;
        checks++;
        if (rv2 !== 1'b1 || s2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_stall: got valid %b stall %b expected 1 1", rv2, s2);
        end
        run_checked("b2b_second", 1'b0, 1'b0, 32'h60, 32'd0, 2'd1, 1'b1);
        run_checked("b2b_err_third", 1'b0, 1'b0, 32'h63, 32'd0, 2'd1, 1'b0);
        run_checked("b2b_fourth", 1'b0, 1'b0, 32'h62, 32'd0, 2'd1, 1'b0);
        idle(1);
    endtask

    task automatic test_latency_one();
        run_checked("lat1_word_load", 1'b1, 1'b0, 32'h40, 32'd0, 2'd2, 1'b0);
        run_checked("lat1_byte_store", 1'b1, 1'b1, 32'h41, 32'h0000_00F0, 2'd0, 1'b0);
        run_checked("lat1_word_reload", 1'b1, 1'b0, 32'h40, 32'd0, 2'd2, 1'b0);
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        int r;
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 8) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) a[15:8] = 8'($urandom_range(1, 255));
            run_checked("random", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        a, $urandom, sz, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        prefill();
        test_reset_mid_wait();
        test_word_latency();
        test_subword();
        test_errors();
        test_back_to_back();
        test_latency_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
